ps2_scancode_rx: RTL and testbench

Upstream stage of the game datapath: receives PS/2 keyboard frames, strips break (F0) and extended (E0) prefixes, and presents the currently held key as a level-held 8-bit make code on `datareceived`. The datapath samples this level every cycle and matches it against the lane codes 1C/1B/23/2B. `datareceived` returns to 0 when that key is released. Framing errors are detected, flagged, and discarded without disturbing the held code.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_line_filter.sv | 42 ++++
 rtl/ps2_scancode_rx.sv | 169 ++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 scancode receiver: protocol prefixes,
// game lane key codes and the frame FSM state encoding.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    localparam logic [7:0] KEY_LANE0 = 8'h1C;
    localparam logic [7:0] KEY_LANE1 = 8'h1B;
    localparam logic [7:0] KEY_LANE2 = 8'h23;
    localparam logic [7:0] KEY_LANE3 = 8'h2B;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // PS/2 uses odd parity over the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return (^data) ^ par;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a glitch filter: the output follows the
// synchronized line only after FILTER_LEN consecutive differing samples.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_line,
    output logic o_filt
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_filt;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_filt  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_filt <= r_sync2;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: frames bytes off the filtered clock, validates them,
// and decodes make/break/extended prefixes into a level-held key code.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] datareceived,
    output logic       extended,
    output logic       make_strobe,
    output logic       break_strobe,
    output logic       frame_err
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic        w_clk_filt;
    logic        w_fall;
    logic        w_timeout;
    logic        w_ok;

    logic        r_dat_s1;
    logic        r_dat_s2;
    logic        r_clk_prev;
    logic [1:0]  r_state;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_par;
    logic        r_stop_bit;
    logic        r_stop_pend;
    logic [15:0] r_idle_cnt;
    logic        r_acc_valid;
    logic        r_acc_err;
    logic [7:0]  r_acc_byte;
    logic        r_brk;
    logic        r_ext;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk    (clk),
        .reset  (reset),
        .i_line (ps2_clk),
        .o_filt (w_clk_filt)
    );

    assign w_fall = r_clk_prev & ~w_clk_filt;
    // An edge in the same cycle as expiry wins: the frame keeps going.
    assign w_timeout = (r_state != ST_IDLE) && !w_fall && (r_idle_cnt >= TO_LAST);
    assign w_ok = odd_parity_ok(r_shift, r_par) & r_stop_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dat_s1    <= 1'b1;
            r_dat_s2    <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_stop_bit  <= 1'b0;
            r_stop_pend <= 1'b0;
            r_idle_cnt  <= '0;
        end else begin
            r_dat_s1    <= ps2_dat;
            r_dat_s2    <= r_dat_s1;
            r_clk_prev  <= w_clk_filt;
            r_stop_pend <= 1'b0;

            if (r_state == ST_IDLE || w_fall) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != 16'hFFFF) begin
                r_idle_cnt <= r_idle_cnt + 16'd1;
            end

            if (w_timeout) begin
                r_state   <= ST_IDLE;
                r_bit_cnt <= '0;
            end else if (w_fall) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!r_dat_s2) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        r_par   <= r_dat_s2;
                        r_state <= ST_STOP;
                    end
                    default: begin
                        r_stop_bit  <= r_dat_s2;
                        r_stop_pend <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Validate stage: a completed frame becomes either an accepted byte or an error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc_valid <= 1'b0;
            r_acc_err   <= 1'b0;
            r_acc_byte  <= '0;
        end else begin
            r_acc_valid <= r_stop_pend & w_ok;
            r_acc_err   <= (r_stop_pend & ~w_ok) | w_timeout;
            r_acc_byte  <= r_shift;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            datareceived <= '0;
            extended     <= 1'b0;
            make_strobe  <= 1'b0;
            break_strobe <= 1'b0;
            frame_err    <= 1'b0;
            r_brk        <= 1'b0;
            r_ext        <= 1'b0;
        end else begin
            make_strobe  <= 1'b0;
            break_strobe <= 1'b0;
            frame_err    <= r_acc_err;
            if (r_acc_err) begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end else if (r_acc_valid) begin
                if (r_acc_byte == PS2_BREAK) begin
                    r_brk <= 1'b1;
                end else if (r_acc_byte == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (r_brk) begin
                    // Releasing a key other than the held one leaves the output alone.
                    if (r_acc_byte == datareceived && r_ext == extended) begin
                        datareceived <= '0;
                        extended     <= 1'b0;
                        break_strobe <= 1'b1;
                    end
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                end else begin
                    if (r_acc_byte != 8'h00 &&
                        (r_acc_byte != datareceived || r_ext != extended)) begin
                        datareceived <= r_acc_byte;
                        extended     <= r_ext;
                        make_strobe  <= 1'b1;
                    end
                    r_ext <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: bit-banged PS/2 frames, strobe counting
// monitor, and immediate-assertion checks against hand-computed values.
module tb_ps2_scancode_rx;
    import ps2_pkg::*;

    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] datareceived;
    logic       extended;
    logic       make_strobe;
    logic       break_strobe;
    logic       frame_err;

    int checks = 0;
    int failures = 0;
    int n_make = 0;
    int n_break = 0;
    int n_err = 0;
    int n_multi = 0;
    int cyc = 0;
    int err_cyc = 0;
    int m0, b0, e0, t_low, d;

    ps2_scancode_rx dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_dat      (ps2_dat),
        .datareceived (datareceived),
        .extended     (extended),
        .make_strobe  (make_strobe),
        .break_strobe (break_strobe),
        .frame_err    (frame_err)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            if (make_strobe)  n_make  <= n_make + 1;
            if (break_strobe) n_break <= n_break + 1;
            if (frame_err) begin
                n_err   <= n_err + 1;
                err_cyc <= cyc;
            end
            if ($countones({make_strobe, break_strobe, frame_err}) > 1) n_multi <= n_multi + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_dat = b;
        wait_cycles(HALF);
        ps2_clk = 1'b0;
        wait_cycles(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(~bad_stop);
        ps2_dat = 1'b1;
        wait_cycles(40);
        @(negedge clk);
        $display("frame %02h par_err=%0b stop_err=%0b -> datareceived=%02h extended=%0b",
                 b, bad_par, bad_stop, datareceived, extended);
    endtask

    task automatic snap();
        m0 = n_make;
        b0 = n_break;
        e0 = n_err;
    endtask

    initial begin
        wait_cycles(5);
        @(negedge clk);
        check("rst_data", 32'(datareceived), 32'h0);
        check("rst_flags", {27'd0, extended, make_strobe, break_strobe, frame_err}, 32'h0);
        reset = 1'b0;
        wait_cycles(20);

        // Press and release 1C
        snap();
        send_frame(KEY_LANE0, 1'b0, 1'b0);
        check("press_1C_data", 32'(datareceived), 32'h1C);
        check("press_1C_make", n_make - m0, 1);
        send_frame(PS2_BREAK, 1'b0, 1'b0);
        send_frame(KEY_LANE0, 1'b0, 1'b0);
        check("rel_1C_data", 32'(datareceived), 32'h0);
        check("rel_1C_break", n_break - b0, 1);
        check("rel_1C_make", n_make - m0, 1);

        // Extended key E0 75
        snap();
        send_frame(PS2_EXT, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        check("ext_data", 32'(datareceived), 32'h75);
        check("ext_flag", 32'(extended), 32'h1);
        send_frame(PS2_EXT, 1'b0, 1'b0);
        send_frame(PS2_BREAK, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        check("ext_rel_data", 32'(datareceived), 32'h0);
        check("ext_rel_flag", 32'(extended), 32'h0);
        check("ext_counts", {n_make - m0, n_break - b0}, {32'd1, 32'd1});

        // Typematic and rollover
        snap();
        send_frame(KEY_LANE1, 1'b0, 1'b0);
        send_frame(KEY_LANE1, 1'b0, 1'b0);
        send_frame(KEY_LANE1, 1'b0, 1'b0);
        check("typ_data", 32'(datareceived), 32'h1B);
        check("typ_make", n_make - m0, 1);
        send_frame(KEY_LANE2, 1'b0, 1'b0);
        check("roll_data", 32'(datareceived), 32'h23);
        send_frame(PS2_BREAK, 1'b0, 1'b0);
        send_frame(KEY_LANE1, 1'b0, 1'b0);
        check("roll_rel_other", 32'(datareceived), 32'h23);
        check("roll_counts", {n_make - m0, n_break - b0}, {32'd2, 32'd0});

        // Release 23, then bad parity / bad stop / good 2B
        send_frame(PS2_BREAK, 1'b0, 1'b0);
        send_frame(KEY_LANE2, 1'b0, 1'b0);
        check("rel_23", 32'(datareceived), 32'h0);
        snap();
        send_frame(KEY_LANE3, 1'b1, 1'b0);
        check("badpar_err", n_err - e0, 1);
        check("badpar_data", 32'(datareceived), 32'h0);
        send_frame(KEY_LANE3, 1'b0, 1'b1);
        check("badstop_err", n_err - e0, 2);
        check("badstop_data", 32'(datareceived), 32'h0);
        send_frame(KEY_LANE3, 1'b0, 1'b0);
        check("good_2B_data", 32'(datareceived), 32'h2B);
        check("good_2B_make", n_make - m0, 1);

        // 5-cycle glitch while idle, with data low so a false start would desync
        snap();
        ps2_dat = 1'b0;
        wait_cycles(10);
        ps2_clk = 1'b0;
        wait_cycles(5);
        ps2_clk = 1'b1;
        wait_cycles(30);
        ps2_dat = 1'b1;
        wait_cycles(10);
        @(negedge clk);
        check("glitch_strobes", {n_make - m0, n_break - b0, n_err - e0}, {32'd0, 32'd0, 32'd0});
        check("glitch_data", 32'(datareceived), 32'h2B);
        send_frame(PS2_BREAK, 1'b0, 1'b0);
        send_frame(KEY_LANE3, 1'b0, 1'b0);
        check("glitch_rel_data", 32'(datareceived), 32'h0);
        check("glitch_rel_counts", {n_break - b0, n_err - e0}, {32'd1, 32'd0});

        // Timeout after start + 4 data bits
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(KEY_LANE0[i]);
        t_low = cyc - HALF;
        wait_cycles(51000);
        @(negedge clk);
        check("to_err", n_err - e0, 1);
        d = err_cyc - t_low;
        $display("timeout frame_err %0d cycles after last ps2_clk fall", d);
        check("to_latency_in_window", 32'(d >= 50000 && d <= 50040), 32'h1);
        check("to_data", 32'(datareceived), 32'h0);
        send_frame(KEY_LANE0, 1'b0, 1'b0);
        check("after_to_data", 32'(datareceived), 32'h1C);
        check("after_to_make", n_make - m0, 1);

        // Reset mid-frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_data", 32'(datareceived), 32'h0);
        check("midrst_flags", {27'd0, extended, make_strobe, break_strobe, frame_err}, 32'h0);
        wait_cycles(5);
        reset = 1'b0;
        wait_cycles(20);
        snap();
        send_frame(KEY_LANE2, 1'b0, 1'b0);
        check("post_rst_data", 32'(datareceived), 32'h23);
        check("post_rst_make", n_make - m0, 1);

        check("strobe_exclusive", n_multi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
